// File: rtl/tp_tx_bridge_if.sv
// Producer and async-stage signals of the sync-to-two-phase bridge.
// The bridge takes the slave modport. The driver side (producer plus
// async stage model) takes the master modport.
interface tp_tx_bridge_if #(
   parameter int DATA_W = 3
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              valid_out;
   logic              ack_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              timeout_err;

   modport master (
      output s_valid, s_data, ack_in,
      input  s_ready, valid_out, data_out, busy, timeout_err
   );

   modport slave (
      input  s_valid, s_data, ack_in,
      output s_ready, valid_out, data_out, busy, timeout_err
   );
endinterface

// File: rtl/tp_tx_bridge.sv
// Synchronous producer FIFO feeding a two-phase bundled-data request channel.
// data_out is loaded once per word and then held for SETUP_CYC cycles before
// valid_out toggles. The word leaves the FIFO only after the synchronized
// acknowledge matches valid_out.
module tp_tx_bridge #(
   parameter int DATA_W      = 3,
   parameter int DEPTH       = 4,
   parameter int SETUP_CYC   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input logic           clk,
   input logic           rst,
   tp_tx_bridge_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SET_W = $clog2(SETUP_CYC + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              ack_s1, ack_s2;
   logic [SET_W-1:0]  set_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q;
   logic              s_ready;
   logic              push, pop;

   // s_ready comes from the registered count only. A pop in the same cycle
   // does not open a slot until the next cycle.
   assign s_ready = (count < CNT_FULL);
   assign push    = bus.s_valid && s_ready && !rst;
   assign pop     = (state == WAIT_ACK) && (ack_s2 == valid_q);

   assign bus.s_ready     = s_ready;
   assign bus.valid_out   = valid_q;
   assign bus.data_out    = data_q;
   assign bus.timeout_err = err_q;
   assign bus.busy        = (count != '0) || (state != IDLE);

   // ack_in is asynchronous to clk. Only the second flop is observed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= bus.ack_in;
         ack_s2 <= ack_s1;
      end
   end

   // FIFO storage. The contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.s_data;
   end

   // Circular pointers and occupancy. Push and pop together leave count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Transfer FSM. The head word is loaded, held through the setup window,
   // and the request is then raised by toggling valid_out. A stale acknowledge
   // (ack_s2 != valid_out) holds the FSM in IDLE and is never counted as a completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         set_cnt <= '0;
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0 && ack_s2 == valid_q) begin
                  data_q  <= mem[rd_ptr];
                  set_cnt <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               set_cnt <= set_cnt + 1'b1;
               if (set_cnt == SET_LAST) begin
                  valid_q <= ~valid_q;
                  tmo_cnt <= '0;
                  state   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_s2 == valid_q) begin
                  state <= IDLE;
               end else if (tmo_cnt != TMO_MAX) begin
                  // The counter saturates and the error flag stays set until reset.
                  // The request stays up: no retransmit and no drop.
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TMO_MAX - 1'b1) err_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tp_tx_bridge.sv
// Directed bench for tp_tx_bridge. Inputs change 1 ns after the rising edge
// and outputs are sampled at the same point. The async stage is modelled either
// by a manual ack level or by a responder that echoes valid_out after 3 ns.
module tb_tp_tx_bridge;
   localparam int DATA_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;

   tp_tx_bridge_if #(.DATA_W(DATA_W)) bus ();

   tp_tx_bridge #(
      .DATA_W(DATA_W), .DEPTH(4), .SETUP_CYC(2), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   logic auto_ack = 1'b0;
   logic ack_man  = 1'b0;
   logic ack_auto_v = 1'b0;
   logic log_en   = 1'b0;
   logic [DATA_W-1:0] seen [$];

   always #5 clk = ~clk;

   assign bus.ack_in = auto_ack ? ack_auto_v : ack_man;

   // Async stage model: acknowledge every request edge 3 ns later.
   always @(bus.valid_out) begin
      #3;
      ack_auto_v = bus.valid_out;
   end

   // Record the bundled data presented at each request toggle.
   always @(bus.valid_out) begin
      if (log_en) seen.push_back(bus.data_out);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.s_valid = 1'b0;
      ticks(2);
      rst = 1'b0;
   endtask

   // Present one word and hold it until accepted. On return, the push edge has passed.
   task automatic push(input logic [DATA_W-1:0] w);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (!bus.s_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("push_timeout", 32'd0, 32'd1);
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (bus.busy && n < max) begin
         tick();
         n++;
      end
      chk("idle_wait", bus.busy, 0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      tick();

      // Reset with a push presented; the push must be discarded.
      rst = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 3'd7;
      ticks(2);
      rst = 1'b0;
      bus.s_valid = 1'b0;
      chk("rst_valid_out", bus.valid_out, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_timeout", bus.timeout_err, 0);
      chk("rst_count", dut.count, 0);

      // Single word: load at edge 1, request at edge 3, pop 3 edges after the ack.
      bus.s_valid = 1'b1;
      bus.s_data  = 3'd1;
      tick();
      bus.s_valid = 1'b0;
      chk("single_e0_data", bus.data_out, 0);
      chk("single_e0_busy", bus.busy, 1);
      tick();
      chk("single_e1_data", bus.data_out, 1);
      chk("single_e1_valid", bus.valid_out, 0);
      tick();
      chk("single_e2_valid", bus.valid_out, 0);
      tick();
      chk("single_e3_valid", bus.valid_out, 1);
      #2 ack_man = 1'b1;
      ticks(2);
      chk("single_e5_busy", bus.busy, 1);
      tick();
      chk("single_e6_busy", bus.busy, 0);
      chk("single_e6_valid", bus.valid_out, 1);

      // Stream of 7 words with the auto-responder.
      ack_man = 1'b0;
      do_reset();
      seen.delete();
      auto_ack = 1'b1;
      log_en = 1'b1;
      for (int i = 1; i <= 4; i++) push(DATA_W'(i));
      chk("stream_full_count", dut.count, 4);
      chk("stream_full_ready", bus.s_ready, 0);
      for (int i = 5; i <= 7; i++) push(DATA_W'(i));
      wait_idle(300);
      chk("stream_toggles", seen.size(), 7);
      for (int i = 0; i < seen.size(); i++) chk($sformatf("stream_word%0d", i), seen[i], i + 1);
      chk("stream_final_valid", bus.valid_out, 1);
      log_en = 1'b0;
      auto_ack = 1'b0;

      // Full boundary: ack held, the 5th word waits at the producer.
      ack_man = 1'b0;
      do_reset();
      for (int i = 1; i <= 4; i++) push(DATA_W'(i));
      chk("full_count", dut.count, 4);
      chk("full_ready", bus.s_ready, 0);
      bus.s_valid = 1'b1;
      bus.s_data  = 3'd5;
      ticks(3);
      chk("full_hold_ready", bus.s_ready, 0);
      chk("full_hold_count", dut.count, 4);
      chk("full_hold_valid", bus.valid_out, 1);
      ack_man = 1'b1;
      ticks(2);
      chk("full_sync_ready", bus.s_ready, 0);
      tick();
      chk("full_pop_ready", bus.s_ready, 1);
      chk("full_pop_count", dut.count, 3);
      tick();
      bus.s_valid = 1'b0;
      chk("full_refill_count", dut.count, 4);
      seen.delete();
      log_en = 1'b1;
      auto_ack = 1'b1;
      wait_idle(300);
      chk("full_drain_n", seen.size(), 4);
      for (int i = 0; i < seen.size(); i++) chk($sformatf("full_drain%0d", i), seen[i], i + 2);
      chk("full_no_timeout", bus.timeout_err, 0);
      log_en = 1'b0;
      auto_ack = 1'b0;

      // Timeout after 8 WAIT_ACK cycles; sticky; the next word is still sent.
      ack_man = 1'b0;
      do_reset();
      push(3'd3);
      ticks(3);
      chk("tmo_req", bus.valid_out, 1);
      ticks(7);
      chk("tmo_before", bus.timeout_err, 0);
      tick();
      chk("tmo_set", bus.timeout_err, 1);
      chk("tmo_still_busy", bus.busy, 1);
      ack_man = 1'b1;
      ticks(3);
      chk("tmo_late_ack_busy", bus.busy, 0);
      chk("tmo_sticky1", bus.timeout_err, 1);
      push(3'd6);
      ticks(3);
      chk("tmo_next_data", bus.data_out, 6);
      chk("tmo_next_valid", bus.valid_out, 0);
      ack_man = 1'b0;
      ticks(3);
      chk("tmo_next_done", bus.busy, 0);
      chk("tmo_sticky2", bus.timeout_err, 1);

      // Reset in the middle of a transfer with 3 words queued.
      do_reset();
      chk("rst2_clears_err", bus.timeout_err, 0);
      push(3'd1);
      push(3'd2);
      push(3'd3);
      tick();
      chk("mid_valid", bus.valid_out, 1);
      chk("mid_count", dut.count, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", bus.valid_out, 0);
      chk("mid_rst_count", dut.count, 0);
      chk("mid_rst_ready", bus.s_ready, 1);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_data", bus.data_out, 0);
      push(3'd4);
      ticks(3);
      chk("mid_new_valid", bus.valid_out, 1);
      chk("mid_new_data", bus.data_out, 4);
      ack_man = 1'b1;
      ticks(3);
      chk("mid_new_done", bus.busy, 0);

      // Spurious ack while idle blocks the next transfer until it is undone.
      ack_man = 1'b0;
      do_reset();
      ack_man = 1'b1;
      ticks(3);
      push(3'd5);
      ticks(6);
      chk("spur_valid", bus.valid_out, 0);
      chk("spur_data", bus.data_out, 0);
      chk("spur_count", dut.count, 1);
      chk("spur_busy", bus.busy, 1);
      ack_man = 1'b0;
      ticks(6);
      chk("spur_resume_valid", bus.valid_out, 1);
      chk("spur_resume_data", bus.data_out, 5);
      ack_man = 1'b1;
      ticks(3);
      chk("spur_done_busy", bus.busy, 0);
      chk("spur_done_count", dut.count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tp_tx_bridge.md
TP_TX_BRIDGE -- requirements
Module: tp_tx_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 3, bundled-data width.
- DEPTH, 4, FIFO entries (power of two).
- SETUP_CYC, 2, clock cycles data_out is stable before valid_out toggles (≥1).
- TIMEOUT_CYC, 255, WAIT_ACK cycles before timeout_err sets.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- s_valid, in, 1, sync producer word valid.
- s_ready, out, 1, FIFO can accept a word.
- s_data, in, DATA_W, sync producer word.
- valid_out, out, 1, two-phase request; each toggle means a new word.
- ack_in, in, 1, two-phase acknowledge from the async stage, asynchronous to clk.
- data_out, out, DATA_W, bundled data for the async stage.
- busy, out, 1, FIFO non-empty or transfer in flight.
- timeout_err, out, 1, sticky, set when an acknowledge is overdue.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.

Function
REQ-004 A push SHALL occur when s_valid && s_ready at a rising edge; s_ready = (count < DEPTH) from registered count, with no same-cycle pop bypass.
REQ-005 The FIFO SHALL be circular, with wrapping read/write pointers and a count of width clog2(DEPTH)+1; a simultaneous push and pop SHALL leave count unchanged.
REQ-006 ack_in SHALL pass through a 2-flop synchronizer (ack_s1, ack_s2); only ack_s2 SHALL be used.
REQ-007 The FSM SHALL have states IDLE, SETUP, WAIT_ACK.
REQ-008 IDLE: if count>0 and ack_s2==valid_out, the next edge SHALL load data_out from the FIFO head, clear the setup counter, and enter SETUP; otherwise the FSM SHALL stay in IDLE.
REQ-009 SETUP: the setup counter SHALL increment each cycle; on the cycle it equals SETUP_CYC-1, the next edge SHALL toggle valid_out, clear the timeout counter, and enter WAIT_ACK.
REQ-010 data_out SHALL change only on the IDLE→SETUP edge, so it is stable for exactly SETUP_CYC cycles before the valid_out toggle and until the next load.
REQ-011 WAIT_ACK: when ack_s2==valid_out, the next edge SHALL pop the FIFO head and return to IDLE.
REQ-012 The minimum period per word SHALL be SETUP_CYC+4 cycles, given ack_in returning instantly: 1 IDLE, SETUP_CYC SETUP, 2 synchronizer, 1 WAIT_ACK detect.
REQ-013 WAIT_ACK: the timeout counter SHALL saturate at TIMEOUT_CYC; on reaching it, timeout_err SHALL be set and remain set until rst; the FSM SHALL keep waiting, with no retransmit and no drop.
REQ-014 busy SHALL be (count>0) || (state!=IDLE).
REQ-015 A push to the FIFO SHALL NOT affect data_out or valid_out of a transfer in flight.
REQ-016 An ack_in toggle while in IDLE or SETUP, which is a spurious or stale acknowledge, SHALL only block IDLE→SETUP until ack_s2==valid_out again; it SHALL never cause a pop.

Reset
REQ-017 On rst at a rising edge, the block SHALL set:
- state=IDLE; FIFO pointers and count = 0.
- valid_out=0, data_out=0, s_ready=1, busy=0, timeout_err=0.
- ack_s1 = ack_s2 = 0; both counters = 0.
REQ-018 rst SHALL override all other inputs in that cycle, and the push in that cycle SHALL be discarded.
REQ-019 Reset mid-transfer SHALL drop all buffered words; if ack_in is then 1, no new transfer SHALL start until the environment returns ack_in to 0, per REQ-008.

Verification
REQ-020 Single word, SETUP_CYC=2: push 3'd1 at edge 0 →
- data_out=1 after edge 1.
- valid_out 0→1 after edge 3.
- Bench toggles ack_in 3 ns later → pop and IDLE within 3 edges; busy=0.
REQ-021 Stream: push 1..7 back-to-back with an auto-responder that toggles ack_in 3 ns after each valid_out change →
- data_out sequence 1,2,...,7 exactly once each.
- valid_out toggles 7 times, ending at 1.
- s_ready drops when count=4.
REQ-022 Full boundary: hold ack_in and push 5 words →
- count=4 and s_ready=0; the 5th word is held by the producer, not lost.
- Toggle ack_in once → s_ready=1 one cycle after the pop edge.
REQ-023 Timeout, TIMEOUT_CYC=8: push one word and never toggle ack_in → timeout_err=1 after 8 WAIT_ACK cycles, stays 1 after a late ack; the next word is then sent normally.
REQ-024 Reset mid-operation: with 3 words queued and valid_out=1, ack_in=0, assert rst for 1 cycle →
- valid_out=0, count=0, s_ready=1.
- Pending ack_in=0 equals valid_out, so a new push transmits normally.
REQ-025 Spurious ack: toggle ack_in while IDLE with the FIFO empty, then push 3'd5 → no pop and no valid_out toggle until ack_in is toggled back.
